ex_mul_unit: RTL and testbench

- Iterative shift-add multiplier in the EX stage. Directly consumes the decode-to-execute pipeline register outputs: EX_mul, EX_a, EX_b, EX_rd and EX_we.
- Produces the low XLEN bits of EX_a*EX_b after a multi-cycle computation.
- Asserts mul_stall so that upstream stages, including the decode-to-execute register, hold while it works.
- Hands the result to the EX/MEM path with a one-shot valid.

---
 rtl/ex_mul_unit.sv | 129 ++++++++++++
 tb/tb_ex_mul_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_unit.sv
// ex_mul_unit: iterative shift-add multiplier (low XLEN bits) in the EX stage.
// Ports: clk, rst (async active-low), EX_* operands in, MEM_stall, flush in;
//   mul_stall (comb hold upstream), mul_valid/mul_result/mul_rd/mul_we out.
// Optional macro MUL_EARLY_TERM_EN: finish once the remaining multiplier is 0.
module ex_mul_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_mul,
  input  logic [XLEN-1:0] EX_a,
  input  logic [XLEN-1:0] EX_b,
  input  logic [4:0]      EX_rd,
  input  logic            EX_we,
  input  logic            MEM_stall,
  input  logic            flush,
  output logic            mul_stall,
  output logic            mul_valid,
  output logic [XLEN-1:0] mul_result,
  output logic [4:0]      mul_rd,
  output logic            mul_we
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] res_hold_q, res_hold_d;
  logic [4:0]      rd_hold_q, rd_hold_d;

  logic [XLEN-1:0] mplier_nx;
  logic            last;
  logic            fin;

  assign mplier_nx = mplier_q >> 1;
  assign last      = (cnt_q == CNT_W'(XLEN-1));

`ifdef MUL_EARLY_TERM_EN
  assign fin = last || (mplier_nx == '0);
`else
  assign fin = last;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    we_d       = we_q;
    res_hold_d = res_hold_q;
    rd_hold_d  = rd_hold_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (EX_mul && !flush) begin
          mcand_d  = EX_a;
          mplier_d = EX_b;
          rd_d     = EX_rd;
          we_d     = EX_we;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      (state_q == BUSY): begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nx;
        cnt_d    = cnt_q + CNT_W'(1);
        if (fin) state_d = DONE;
      end
      (state_q == DONE): begin
        // Keep the presented values once DONE is left.
        res_hold_d = acc_q;
        rd_hold_d  = rd_q;
        if (!MEM_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      res_hold_q <= '0;
      rd_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      res_hold_q <= res_hold_d;
      rd_hold_q  <= rd_hold_d;
    end
  end

  logic done;
  assign done = (state_q == DONE);

  assign mul_stall  = !flush &&
                      (((state_q == IDLE) && EX_mul) ||
                       (state_q == BUSY));
  assign mul_valid  = done && !flush;
  assign mul_we     = mul_valid && we_q;
  assign mul_result = done ? acc_q : res_hold_q;
  assign mul_rd     = done ? rd_q : rd_hold_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
// tb_ex_mul_unit: scoreboard bench for ex_mul_unit.
// Expected products queued at issue, popped when mul_valid rises.
module tb_ex_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_mul;
  logic [31:0] EX_a;
  logic [31:0] EX_b;
  logic [4:0]  EX_rd;
  logic        EX_we;
  logic        MEM_stall;
  logic        flush;
  logic        mul_stall;
  logic        mul_valid;
  logic [31:0] mul_result;
  logic [4:0]  mul_rd;
  logic        mul_we;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ex_mul_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .EX_mul(EX_mul),
    .EX_a(EX_a),
    .EX_b(EX_b),
    .EX_rd(EX_rd),
    .EX_we(EX_we),
    .MEM_stall(MEM_stall),
    .flush(flush),
    .mul_stall(mul_stall),
    .mul_valid(mul_valid),
    .mul_result(mul_result),
    .mul_rd(mul_rd),
    .mul_we(mul_we)
  );

  function automatic int busy_cycles(input logic [31:0] b);
    int n;
    logic [31:0] m;
`ifdef MUL_EARLY_TERM_EN
    n = 1;
    m = b >> 1;
    while (m != 0 && n < 32) begin
      m = m >> 1;
      n++;
    end
`else
    m = b;
    n = 32;
`endif
    return n;
  endfunction

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic we,
                         input int hold);
    int   n;
    int   v;
    exp_t e;
    exp_t got;
    @(negedge clk);
    EX_mul = 1'b1;
    EX_a   = a;
    EX_b   = b;
    EX_rd  = rd;
    EX_we  = we;
    e.res  = a * b;
    e.rd   = rd;
    e.we   = we;
    sb.push_back(e);
    n = 0;
    #1;
    while (!mul_valid && n < 200) begin
      if (mul_stall) n++;
      if (mul_we) begin
        checks++;
        errors++;
        $display("FAIL we_outside_done got=1 exp=0");
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (n !== busy_cycles(b) + 1) begin
      errors++;
      $display("FAIL stall_cycles got=%0d exp=%0d", n, busy_cycles(b) + 1);
    end
    if (!mul_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout got=0 exp=1");
      return;
    end
    EX_mul = 1'b0;
    got = sb.pop_front();
    v = 0;
    while (mul_valid && v < 20) begin
      checks++;
      if ({mul_result, mul_rd, mul_we, mul_stall} !==
          {got.res, got.rd, got.we, 1'b0}) begin
        errors++;
        $display("FAIL done_out got=%h/%0d/%b/%b exp=%h/%0d/%b/0",
                 mul_result, mul_rd, mul_we, mul_stall,
                 got.res, got.rd, got.we);
      end
      MEM_stall = (v < hold);
      v++;
      @(negedge clk);
      #1;
    end
    MEM_stall = 1'b0;
    checks++;
    if (v !== hold + 1) begin
      errors++;
      $display("FAIL valid_cycles got=%0d exp=%0d", v, hold + 1);
    end
    checks++;
    if ({mul_stall, mul_we, mul_result, mul_rd} !==
        {1'b0, 1'b0, got.res, got.rd}) begin
      errors++;
      $display("FAIL idle_hold got=%b/%b/%h/%0d exp=0/0/%h/%0d",
               mul_stall, mul_we, mul_result, mul_rd, got.res, got.rd);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    EX_mul    = 1'b0;
    EX_a      = '0;
    EX_b      = '0;
    EX_rd     = '0;
    EX_we     = 1'b0;
    MEM_stall = 1'b0;
    flush     = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mul_stall, mul_valid, mul_result, mul_rd, mul_we} !== '0) begin
      errors++;
      $display("FAIL reset_out got=%b/%b/%h/%0d/%b exp=all0",
               mul_stall, mul_valid, mul_result, mul_rd, mul_we);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_mul(32'd7, 32'd6, 5'd5, 1'b1, 0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, 0);
    run_mul(32'h8000_0000, 32'd2, 5'd31, 1'b1, 0);
    run_mul(32'h1234_5678, 32'h9ABC_DEF1, 5'd17, 1'b1, 0);
  endtask

  task automatic test_mem_stall;
    run_mul(32'd3, 32'd4, 5'd9, 1'b1, 3);
  endtask

  task automatic test_early_term;
    run_mul(32'd10, 32'd3, 5'd1, 1'b1, 0);
    run_mul(32'd10, 32'd0, 5'd2, 1'b1, 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      run_mul($urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1, 0);
    end
  endtask

  task automatic test_flush;
    int fl;
    int seen;
    fl = busy_cycles(32'd9) > 10 ? 10 : busy_cycles(32'd9) - 1;
    @(negedge clk);
    EX_mul = 1'b1;
    EX_a   = 32'd9;
    EX_b   = 32'd9;
    EX_rd  = 5'd7;
    EX_we  = 1'b1;
    repeat (fl) @(negedge clk);
    flush  = 1'b1;
    EX_mul = 1'b0;
    #1;
    checks++;
    if ({mul_stall, mul_valid, mul_we} !== 3'b000) begin
      errors++;
      $display("FAIL flush_cycle got=%b%b%b exp=000",
               mul_stall, mul_valid, mul_we);
    end
    @(negedge clk);
    flush = 1'b0;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (mul_valid || mul_stall) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_idle got=%0d exp=0", seen);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    EX_mul = 1'b1;
    EX_a   = 32'hFFFF;
    EX_b   = 32'hFFFF;
    EX_rd  = 5'd12;
    repeat (5) @(negedge clk);
    EX_mul = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({mul_stall, mul_valid, mul_result, mul_rd} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%b/%b/%h/%0d exp=all0",
               mul_stall, mul_valid, mul_result, mul_rd);
    end
    @(negedge clk);
    rst = 1'b1;
    run_mul(32'd5, 32'd5, 5'd4, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_stall();
    test_early_term();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
